// File: rtl/alu_exec.sv
// alu_exec -- execute-stage ALU with a valid/ready handshake on both sides.
//
// Logic, add/sub, move and conditional-select ops complete in one cycle.
// Shifts (LSL/ASL/LSR/ASR) run iteratively, one bit per clock, so a shift by n
// presents its result n+1 cycles after accept. Shift by 0 completes in one cycle.
//
// Ports:
//   i_clk     clock, all state updates on the rising edge
//   i_rst     synchronous active-high reset
//   i_valid   op and operands present
//   o_ready   block accepts an op this cycle
//   i_alu_do  4-bit ALU_* op code
//   i_a       operand A
//   i_b       operand B / shift amount (low SHW bits)
//   o_valid   result available
//   i_ready   downstream accepts the result
//   o_result  result
//   o_flags   {Z,N,C,V} of the most recently completed op
module alu_exec #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_alu_do,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags
);

    // ALU_* op codes shared with the decoder; 4'hC..4'hF are undefined.
    localparam logic [3:0] ALU_NOP = 4'h0;
    localparam logic [3:0] ALU_MOV = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h3;
    localparam logic [3:0] ALU_AND = 4'h4;
    localparam logic [3:0] ALU_OR  = 4'h5;
    localparam logic [3:0] ALU_XOR = 4'h6;
    localparam logic [3:0] ALU_LSL = 4'h7;
    localparam logic [3:0] ALU_LSR = 4'h8;
    localparam logic [3:0] ALU_ASR = 4'h9;
    localparam logic [3:0] ALU_ASL = 4'hA;
    localparam logic [3:0] ALU_CND = 4'hB;

    // Flag bit positions inside o_flags.
    localparam int FZ = 3;
    localparam int FN = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e           state_q;
    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] sh_q;     // working value during an iterative shift
    logic [SHW-1:0]   cnt_q;    // shifts still to perform
    logic [3:0]       op_q;     // shift op latched at accept

    logic             accept;
    logic             is_shift;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             upd_zn;
    logic [WIDTH-1:0] acc_res;
    logic [3:0]       acc_flags;
    logic [WIDTH-1:0] step_val;
    logic             step_c;

    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_flags  = flags_q;

    always_comb begin
        o_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && i_ready);
        accept  = i_valid && o_ready;
    end

    // Single-cycle datapath evaluated on the incoming op.
    always_comb begin
        amt      = i_b[SHW-1:0];
        is_shift = (i_alu_do == ALU_LSL) || (i_alu_do == ALU_ASL) ||
                   (i_alu_do == ALU_LSR) || (i_alu_do == ALU_ASR);
        // SUB is done as A + ~B + 1 so C is the inverted borrow.
        b_eff    = (i_alu_do == ALU_SUB) ? ~i_b : i_b;
        sum      = {1'b0, i_a} + {1'b0, b_eff} +
                   {{WIDTH{1'b0}}, (i_alu_do == ALU_SUB)};
        acc_res   = result_q;
        acc_flags = flags_q;
        upd_zn    = 1'b0;
        case (i_alu_do)
            ALU_MOV: begin
                acc_res = i_b;
                upd_zn  = 1'b1;
            end
            ALU_ADD, ALU_SUB: begin
                acc_res       = sum[WIDTH-1:0];
                acc_flags[FC] = sum[WIDTH];
                acc_flags[FV] = (i_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                                (sum[WIDTH-1] != i_a[WIDTH-1]);
                upd_zn        = 1'b1;
            end
            ALU_AND: begin
                acc_res = i_a & i_b;
                upd_zn  = 1'b1;
            end
            ALU_OR: begin
                acc_res = i_a | i_b;
                upd_zn  = 1'b1;
            end
            ALU_XOR: begin
                acc_res = i_a ^ i_b;
                upd_zn  = 1'b1;
            end
            ALU_LSL, ALU_ASL, ALU_LSR, ALU_ASR: begin
                // Only the zero-amount case completes here; C is kept.
                acc_res       = i_a;
                acc_flags[FV] = 1'b0;
                upd_zn        = 1'b1;
            end
            ALU_CND: begin
                acc_res = flags_q[FZ] ? i_b : i_a;
            end
            default: begin
            end
        endcase
        if (upd_zn) begin
            acc_flags[FZ] = (acc_res == '0);
            acc_flags[FN] = acc_res[WIDTH-1];
        end
    end

    // One-bit shift step for the iterative path.
    always_comb begin
        step_val = sh_q;
        step_c   = 1'b0;
        case (op_q)
            ALU_LSL, ALU_ASL: begin
                step_val = {sh_q[WIDTH-2:0], 1'b0};
                step_c   = sh_q[WIDTH-1];
            end
            ALU_LSR: begin
                step_val = {1'b0, sh_q[WIDTH-1:1]};
                step_c   = sh_q[0];
            end
            ALU_ASR: begin
                step_val = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
                step_c   = sh_q[0];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (is_shift && (amt != '0)) begin
                            sh_q    <= i_a;
                            cnt_q   <= amt;
                            op_q    <= i_alu_do;
                            valid_q <= 1'b0;
                            state_q <= S_SHIFT;
                        end else begin
                            result_q <= acc_res;
                            flags_q  <= acc_flags;
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end else if (state_q == S_DONE && i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    sh_q  <= step_val;
                    cnt_q <= cnt_q - SHW'(1);
                    // Final step writes result and flags directly.
                    if (cnt_q == SHW'(1)) begin
                        result_q <= step_val;
                        flags_q  <= {(step_val == '0), step_val[WIDTH-1], step_c, 1'b0};
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
